au_incdec_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational incrementer in the arithmetic-unit library. It adds or subtracts one from a WIDTH-bit operand, and the carry/borrow chain is split across STAGES register stages. It offers wrap or saturate modes and a valid/ready handshake with full backpressure. It sits between streaming datapath blocks wherever a wide increment cannot close timing in one cycle.

---
 rtl/au_pkg.sv | 23 ++
 rtl/au_incdec_chunk.sv | 54 +++++
 rtl/au_incdec_pipe.sv | 146 ++++++++++++++
 tb/tb_au_incdec_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// -----------------------------------------------------------------------------
// au_pkg -- shared definitions for the arithmetic-unit increment/decrement
// pipeline.
//   au_cdiv()    : ceiling division, used to size the per-stage carry chunk
//   AU_ARCH_*    : per-chunk adder architecture encodings (same values as the
//                  combinational incrementer)
//   au_mode_t    : {dec, sat} operation mode carried alongside each beat
// -----------------------------------------------------------------------------
package au_pkg;

  localparam int AU_ARCH_RIPPLE = 0;
  localparam int AU_ARCH_PREFIX = 1;

  typedef struct packed {
    logic dec;  // 1 = subtract one, 0 = add one
    logic sat;  // 1 = clamp on carry/borrow out, 0 = wrap
  } au_mode_t;

  function automatic int au_cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/au_incdec_chunk.sv
// -----------------------------------------------------------------------------
// au_incdec_chunk -- combinational +/-cin on one CW-bit slice of the operand.
//   i_x    [CW-1:0]  operand slice
//   i_cin            carry (inc) or borrow (dec) into the slice
//   i_dec            1 = decrement, 0 = increment
//   o_res  [CW-1:0]  slice result
//   o_cout           carry/borrow out of the slice
// Adding or subtracting a single bit only flips bit i when every lower bit
// "propagates" (all ones for inc, all zeros for dec), so both architectures
// reduce to a prefix-AND of the propagate vector; ARCH picks linear or
// log-depth evaluation of that prefix.
// -----------------------------------------------------------------------------
module au_incdec_chunk
  import au_pkg::*;
#(
  parameter int CW   = 8,
  parameter int ARCH = AU_ARCH_RIPPLE
) (
  input  logic [CW-1:0] i_x,
  input  logic          i_cin,
  input  logic          i_dec,
  output logic [CW-1:0] o_res,
  output logic          o_cout
);

  logic [CW-1:0] w_prop;  // bit i lets a carry/borrow pass through
  logic [CW-1:0] w_pre;   // w_pre[i] = &w_prop[i:0]
  logic [CW:0]   w_cvec;  // w_cvec[i] = carry into bit i (before gating by cin)

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block can leave it holding a stale value
    // (which would infer a latch).
    w_pre  = '0;
    w_prop = i_dec ? ~i_x : i_x;
    if (ARCH == AU_ARCH_PREFIX) begin
      // Kogge-Stone style prefix AND: after step d, bit i covers 2*d bits.
      w_pre = w_prop;
      for (int d = 1; d < CW; d = d * 2) begin
        w_pre = w_pre & ((w_pre << d) | ({CW{1'b1}} >> (CW - d)));
      end
    end else begin
      w_pre[0] = w_prop[0];
      for (int i = 1; i < CW; i++) begin
        w_pre[i] = w_pre[i-1] & w_prop[i];
      end
    end
  end

  assign w_cvec = {w_pre, 1'b1};
  assign o_res  = i_x ^ ({CW{i_cin}} & w_cvec[CW-1:0]);
  assign o_cout = i_cin & w_cvec[CW];

endmodule

// File: rtl/au_incdec_pipe.sv
// -----------------------------------------------------------------------------
// au_incdec_pipe -- pipelined WIDTH-bit +/-1 with wrap or saturate and a
// valid/ready handshake with full backpressure.
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational from
//                       out_ready and the stage valid registers only)
//   a [WIDTH-1:0]       operand
//   dec, sat            1 = decrement / 1 = saturate
//   out_valid/out_ready output handshake
//   z [WIDTH-1:0]       result, co = unsaturated carry/borrow out
// Stage k resolves chunk k of the carry chain; upper bits ride along raw.
// Each stage holds one beat, so the pipe holds exactly STAGES beats and
// bubbles collapse through the advance chain.
// -----------------------------------------------------------------------------
module au_incdec_pipe
  import au_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int ARCH   = AU_ARCH_RIPPLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             dec,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             co
);

  localparam int CW = au_cdiv(WIDTH, STAGES);

  // Stage registers
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_data [STAGES];
  au_mode_t          r_mode [STAGES];

  // Per-stage inputs (from the previous stage or the input port) and results
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_cnext;
  logic [WIDTH-1:0]  w_din   [STAGES];
  logic [WIDTH-1:0]  w_dnext [STAGES];
  au_mode_t          w_mode_in [STAGES];

  // A stage may load when it is empty or its successor is moving on.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = ~r_valid[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = ~r_valid[k] | w_adv[k+1];
    end
  end

  always_comb begin
    w_vin     = '0;
    w_cin     = '0;
    w_din     = '{default: '0};
    w_mode_in = '{default: '0};
    w_vin[0]  = in_valid;
    w_din[0]  = a;
    w_cin[0]  = 1'b1;  // the +/-1 enters as carry/borrow into chunk 0
    w_mode_in[0].dec = dec;
    w_mode_in[0].sat = sat;
    for (int k = 1; k < STAGES; k++) begin
      w_vin[k]     = r_valid[k-1];
      w_din[k]     = r_data[k-1];
      w_cin[k]     = r_carry[k-1];
      w_mode_in[k] = r_mode[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CW;
    if (LO >= WIDTH) begin : g_empty
      // Chunk lies entirely above the operand: pass data and carry through.
      assign w_dnext[k] = w_din[k];
      assign w_cnext[k] = w_cin[k];
    end else begin : g_chunk
      localparam int HI = ((k + 1) * CW < WIDTH) ? (k + 1) * CW - 1 : WIDTH - 1;
      logic [HI-LO:0] w_res;
      logic [WIDTH-1:0] w_merged;

      au_incdec_chunk #(
        .CW   (HI - LO + 1),
        .ARCH (ARCH)
      ) u_chunk (
        .i_x    (w_din[k][HI:LO]),
        .i_cin  (w_cin[k]),
        .i_dec  (w_mode_in[k].dec),
        .o_res  (w_res),
        .o_cout (w_cnext[k])
      );

      always_comb begin
        w_merged        = w_din[k];
        w_merged[HI:LO] = w_res;
      end
      assign w_dnext[k] = w_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset too, not just the valids, because
      // z and co must read zero out of reset; the per-stage arrays are small
      // flop banks, not RAM, so a reset loop over them is fine.
      r_valid <= '0;
      r_carry <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
        r_mode[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every stage samples its
      // predecessor's pre-edge value regardless of loop order.
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= w_vin[k];
          // Bubbles leave the data alone; only real beats overwrite it.
          if (w_vin[k]) begin
            r_data[k]  <= w_dnext[k];
            r_carry[k] <= w_cnext[k];
            r_mode[k]  <= w_mode_in[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[STAGES-1];
  assign co        = r_carry[STAGES-1];

  // Saturation mux: a carry/borrow out of the top chunk clamps to the rail.
  assign z = (r_mode[STAGES-1].sat & r_carry[STAGES-1])
             ? {WIDTH{~r_mode[STAGES-1].dec}}
             : r_data[STAGES-1];

endmodule

// File: tb/tb_au_incdec_pipe.sv
// -----------------------------------------------------------------------------
// tb_au_incdec_pipe -- self-checking bench for au_incdec_pipe.
// Five instances run side by side:
//   0: WIDTH=8,  STAGES=2,  ripple   (directed cases)
//   1: WIDTH=13, STAGES=4,  prefix   (non-divisible width)
//   2: WIDTH=8,  STAGES=8,  prefix   (STAGES = WIDTH)
//   3: WIDTH=32, STAGES=3,  ripple
//   4: WIDTH=64, STAGES=1,  prefix
// Expected results come from a full-width arithmetic model pushed into a
// per-instance FIFO on every accepted beat and popped on every delivered beat.
// -----------------------------------------------------------------------------
module tb_au_incdec_pipe;

  localparam int N = 5;

  function automatic int cfg_w(input int i);
    case (i)
      0:       return 8;
      1:       return 13;
      2:       return 8;
      3:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      2:       return 8;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_arch(input int i);
    return (i == 0 || i == 3) ? 0 : 1;
  endfunction

  function automatic logic [64:0] mask_of(input int w);
    return (65'd1 << w) - 65'd1;
  endfunction

  // Reference: plain full-width arithmetic; returns {co, z}.
  function automatic logic [64:0] golden(input int w, input logic [63:0] a,
                                         input logic d, input logic s);
    logic [64:0] m;
    logic [64:0] av;
    logic [64:0] r;
    logic        c;
    m  = mask_of(w);
    av = {1'b0, a} & m;
    if (!d) begin
      r = av + 65'd1;
      c = (r > m);
    end else begin
      c = (av == 65'd0);
      r = av - 65'd1;
    end
    r = r & m;
    if (s && c) r = d ? 65'd0 : m;
    return {c, r[63:0]};
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       in_valid_v;
  logic [N-1:0]       dec_v;
  logic [N-1:0]       sat_v;
  logic [N-1:0]       out_ready_v;
  logic [N-1:0][63:0] a_v;
  wire  [N-1:0]       in_ready_v;
  wire  [N-1:0]       out_valid_v;
  wire  [N-1:0]       co_v;
  wire  [N-1:0][63:0] z_v;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int W = cfg_w(gi);
    logic [W-1:0] z_w;

    au_incdec_pipe #(
      .WIDTH  (W),
      .STAGES (cfg_s(gi)),
      .ARCH   (cfg_arch(gi))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_v[gi]),
      .a         (a_v[gi][W-1:0]),
      .dec       (dec_v[gi]),
      .sat       (sat_v[gi]),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready_v[gi]),
      .z         (z_w),
      .co        (co_v[gi])
    );

    assign z_v[gi] = 64'(z_w);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int wp    [N];
  int rp    [N];
  int n_out [N];
  logic [64:0] exp_mem [N][128];

  task automatic check(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample just after the falling edge, update the scoreboard, then move to
  // the next falling edge. Inputs are always changed at falling edges.
  task automatic tick();
    #1;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid_v[i] && in_ready_v[i]) begin
          exp_mem[i][wp[i] % 128] = golden(cfg_w(i), a_v[i], dec_v[i], sat_v[i]);
          wp[i]++;
          n_acc++;
        end
        if (out_valid_v[i] && out_ready_v[i]) begin
          check($sformatf("sb_occupied[%0d]", i), 65'(wp[i] != rp[i]), 65'd1);
          if (wp[i] != rp[i]) begin
            check($sformatf("sb_beat[%0d]", i), {co_v[i], z_v[i]},
                  exp_mem[i][rp[i] % 128]);
            rp[i]++;
          end
          n_out[i]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One beat into an otherwise idle instance: checks acceptance, latency and
  // the result against a hand-derived constant.
  task automatic send_one(input int i, input logic [63:0] a, input logic d,
                          input logic s, input logic [64:0] exp, input string tag);
    int lat;
    in_valid_v[i]  = 1'b1;
    a_v[i]         = a;
    dec_v[i]       = d;
    sat_v[i]       = s;
    out_ready_v[i] = 1'b1;
    #1;
    check({tag, "_in_ready"}, 65'(in_ready_v[i]), 65'd1);
    tick();
    in_valid_v[i] = 1'b0;
    lat = 1;
    while (!out_valid_v[i] && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 65'(lat), 65'(cfg_s(i)));
    check({tag, "_result"}, {co_v[i], z_v[i]}, exp);
    tick();
  endtask

  initial begin
    int base;
    int cyc;
    logic [64:0] m;

    rst         = 1'b1;
    in_valid_v  = '0;
    dec_v       = '0;
    sat_v       = '0;
    out_ready_v = '1;
    a_v         = '0;
    for (int i = 0; i < N; i++) begin
      wp[i] = 0;
      rp[i] = 0;
      n_out[i] = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 65'(out_valid_v), 65'd0);
    check("rst_co", 65'(co_v), 65'd0);
    for (int i = 0; i < N; i++) check($sformatf("rst_z[%0d]", i), 65'(z_v[i]), 65'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 65'(in_ready_v), 65'h1f);
    check("rel_out_valid", 65'(out_valid_v), 65'd0);

    // Directed single beats, 8-bit / 2 stages
    send_one(0, 64'h7f, 1'b0, 1'b0, {1'b0, 64'h80}, "inc_7f");
    send_one(0, 64'hff, 1'b0, 1'b0, {1'b1, 64'h00}, "inc_ff_wrap");
    send_one(0, 64'hff, 1'b0, 1'b1, {1'b1, 64'hff}, "inc_ff_sat");
    send_one(0, 64'h00, 1'b1, 1'b0, {1'b1, 64'hff}, "dec_00_wrap");
    send_one(0, 64'h00, 1'b1, 1'b1, {1'b1, 64'h00}, "dec_00_sat");
    send_one(0, 64'h80, 1'b1, 1'b1, {1'b0, 64'h7f}, "dec_80_sat");

    // Non-divisible width, 13-bit / 4 stages
    send_one(1, 64'h0fff, 1'b0, 1'b0, {1'b0, 64'h1000}, "w13_inc_0fff");
    send_one(1, 64'h1fff, 1'b0, 1'b0, {1'b1, 64'h0000}, "w13_inc_1fff");
    send_one(1, 64'h1000, 1'b1, 1'b0, {1'b0, 64'h0fff}, "w13_dec_1000");

    // Backpressure: pipe of 2 fills, then drains in order
    base = n_out[0];
    out_ready_v[0] = 1'b0;
    in_valid_v[0]  = 1'b1;
    dec_v[0]       = 1'b0;
    sat_v[0]       = 1'b0;
    a_v[0]         = 64'h10;
    #1 check("bp_ready_0", 65'(in_ready_v[0]), 65'd1);
    tick();
    a_v[0] = 64'h11;
    #1 check("bp_ready_1", 65'(in_ready_v[0]), 65'd1);
    tick();
    a_v[0] = 64'h12;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_stall_ready", 65'(in_ready_v[0]), 65'd0);
      check("bp_stall_out", {out_valid_v[0], z_v[0]}, {1'b1, 64'h11});
      tick();
    end
    out_ready_v[0] = 1'b1;
    #1 check("bp_release_ready", 65'(in_ready_v[0]), 65'd1);
    tick();
    a_v[0] = 64'h13;
    #1 check("bp_last_ready", 65'(in_ready_v[0]), 65'd1);
    tick();
    in_valid_v[0] = 1'b0;
    for (int c = 0; c < 10 && wp[0] != rp[0]; c++) tick();
    check("bp_out_count", 65'(n_out[0] - base), 65'd4);
    check("bp_drained", 65'(wp[0] - rp[0]), 65'd0);

    // Reset with two beats in flight
    out_ready_v[0] = 1'b0;
    in_valid_v[0]  = 1'b1;
    a_v[0]         = 64'h40;
    tick();
    a_v[0] = 64'h41;
    tick();
    in_valid_v[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 65'(out_valid_v[0]), 65'd0);
    check("mid_rst_z", {co_v[0], z_v[0]}, 65'd0);
    for (int i = 0; i < N; i++) rp[i] = wp[i];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("post_rst_out_valid", 65'(out_valid_v[0]), 65'd0);
      check("post_rst_in_ready", 65'(in_ready_v[0]), 65'd1);
      tick();
    end

    // Random traffic on every instance
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 40000) begin
      for (int i = 0; i < N; i++) begin
        m = mask_of(cfg_w(i));
        in_valid_v[i]  = 1'($urandom_range(0, 1));
        out_ready_v[i] = 1'($urandom_range(0, 1));
        dec_v[i]       = 1'($urandom_range(0, 1));
        sat_v[i]       = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0:       a_v[i] = 64'd0;
          1:       a_v[i] = m[63:0];
          2:       a_v[i] = m[63:0] ^ 64'(1);
          default: a_v[i] = {$urandom(), $urandom()} & m[63:0];
        endcase
      end
      tick();
      cyc++;
    end
    check("rand_beats_done", 65'(n_acc >= 10000), 65'd1);

    // Drain everything still in flight
    in_valid_v  = '0;
    out_ready_v = '1;
    for (int c = 0; c < 50; c++) tick();
    for (int i = 0; i < N; i++) begin
      check($sformatf("drain_empty[%0d]", i), 65'(wp[i] - rp[i]), 65'd0);
    end
    check("drain_out_valid", 65'(out_valid_v), 65'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
